// File: rtl/mem_bus_arbiter_if.sv
// Request/grant bundle for both bus masters plus the shared data-memory slave port.
// The slave modport is the arbiter's view; the master modport is the requesters'/memory view.
interface mem_bus_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic [DW-1:0] m0_rdata;
  logic          m0_rvalid;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic [DW-1:0] m1_rdata;
  logic          m1_rvalid;

  logic          s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  s_rdata,
    output m0_gnt, m0_rdata, m0_rvalid,
    output m1_gnt, m1_rdata, m1_rvalid,
    output s_we, s_addr, s_wdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output s_rdata,
    input  m0_gnt, m0_rdata, m0_rvalid,
    input  m1_gnt, m1_rdata, m1_rvalid,
    input  s_we, s_addr, s_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the single data-memory/IO port: IDLE -> ACCESS -> RESP per word access.
// Round-robin by default; define ARB_FIXED_PRIO_EN to give master 0 fixed priority.
module mem_bus_arbiter #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             reset,
  mem_bus_arbiter_if.slave bus,
  output logic             busy,
  output logic             owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          ptr;
  logic          ptr_nxt;
  logic          winner;
  logic          any_req;
  logic          load;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;

  // In fixed-priority mode the pointer never leaves 0, so the same
  // tie-break below hands every simultaneous request to master 0.
  always_comb begin
    any_req = bus.m0_req | bus.m1_req;
    if (bus.m0_req && bus.m1_req) begin
      winner = ptr;
    end else begin
      winner = bus.m1_req;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE, RESP: begin
        if (any_req) begin
          state_nxt = ACCESS;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACCESS:  state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    ptr_nxt = 1'b0;
`else
    ptr_nxt = load ? ~winner : ptr;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      if (load) begin
        owner     <= winner;
        cmd_we    <= winner ? bus.m1_we    : bus.m0_we;
        cmd_addr  <= winner ? bus.m1_addr  : bus.m0_addr;
        cmd_wdata <= winner ? bus.m1_wdata : bus.m0_wdata;
      end
    end
  end

  // Read data is captured at the edge closing ACCESS and held per master
  // until that master's next read completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (state == ACCESS && !cmd_we) begin
      if (owner) begin
        rdata1 <= bus.s_rdata;
      end else begin
        rdata0 <= bus.s_rdata;
      end
    end
  end

  // Outputs decode straight from state so an asynchronous reset during
  // ACCESS kills s_we and gnt immediately, aborting the write.
  always_comb begin
    busy          = (state != IDLE);
    bus.s_we      = (state == ACCESS) && cmd_we;
    bus.s_addr    = cmd_addr;
    bus.s_wdata   = cmd_wdata;
    bus.m0_gnt    = (state == ACCESS) && !owner;
    bus.m1_gnt    = (state == ACCESS) &&  owner;
    bus.m0_rvalid = (state == RESP) && !cmd_we && !owner;
    bus.m1_rvalid = (state == RESP) && !cmd_we &&  owner;
    bus.m0_rdata  = rdata0;
    bus.m1_rdata  = rdata1;
  end

endmodule
